// File: rtl/shift_issue_pkg.sv
// shift_issue_pkg
//   Shared definitions for the shift issue stage and the downstream shifter:
//   operand width, Shiftop codes, R-type opcode, shift funct codes and the
//   skid-buffer state encodings.  Also provides a helper that recognises the
//   six legal shift funct codes.
package shift_issue_pkg;

  localparam int SHIFT_DATA_WIDTH = 32;

  // Shiftop codes understood by the shifter
  localparam logic [1:0] SHIFTOP_LEFT       = 2'b00;
  localparam logic [1:0] SHIFTOP_LOGI_RIGHT = 2'b10;
  localparam logic [1:0] SHIFTOP_ALGO_RIGHT = 2'b11;

  // R-type opcode and shift funct codes
  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] FUNCT_SLL    = 6'b000000;
  localparam logic [5:0] FUNCT_SRL    = 6'b000010;
  localparam logic [5:0] FUNCT_SRA    = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV   = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV   = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV   = 6'b000111;

  // Skid-buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_e;

  // True when funct selects one of the six shift operations
  function automatic logic is_shift_funct(input logic [5:0] funct);
    logic hit;
    case (funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/shift_decode.sv
// shift_decode
//   Combinational decode of a MIPS R-type shift instruction into shifter
//   operands.  Illegal instructions yield illegal=1, Shiftop=00, B=0 while
//   A and dest pass through unchanged.
// Ports:
//   inst     in   instruction word
//   rs_val   in   rs register value (low 5 bits give variable shift amount)
//   rt_val   in   rt register value (becomes operand A)
//   a        out  shifter operand A
//   b        out  shift amount
//   shiftop  out  shift operation code
//   dest     out  destination register rd
//   illegal  out  instruction is not a legal shift
module shift_decode
  import shift_issue_pkg::*;
#(
  parameter int DATA_WIDTH = SHIFT_DATA_WIDTH
) (
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic [DATA_WIDTH-1:0] a,
  output logic [4:0]            b,
  output logic [1:0]            shiftop,
  output logic [4:0]            dest,
  output logic                  illegal
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       legal_s;

  // Fields the decode never looks at (rs/rt specifiers, upper rs bits)
  logic       unused_s;

  assign opcode_s = inst[31:26];
  assign funct_s  = inst[5:0];
  assign legal_s  = (opcode_s == OPCODE_RTYPE) && is_shift_funct(funct_s);
  assign unused_s = ^{inst[25:16], rs_val[DATA_WIDTH-1:5]};

  // Operand selection: funct[2] picks variable (rs) versus immediate shamt
  always_comb begin
    a       = rt_val;
    dest    = inst[15:11];
    illegal = 1'b0;
    b       = 5'd0;
    shiftop = SHIFTOP_LEFT;
    if (legal_s) begin
      shiftop = funct_s[1:0];
      if (funct_s[2]) begin
        b = rs_val[4:0];
      end else begin
        b = inst[10:6];
      end
    end else begin
      illegal = 1'b1;
      b       = 5'd0;
      shiftop = SHIFTOP_LEFT;
    end
  end

endmodule

// File: rtl/shift_issue.sv
// shift_issue
//   Decode/issue stage feeding the combinational shifter.  Decodes R-type
//   shift instructions and queues the results in a 2-entry skid buffer so
//   the shifter sees registered, stable operands.  Slot0 is always the head.
//   Optional macro SHIFT_ISSUE_PERF_EN adds issue/stall performance counters;
//   without it perf_issued/perf_stall are tied to 0.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_inst             instruction word
//   in_rs_val/in_rt_val register operands
//   out_valid/out_ready downstream handshake
//   out_A/out_B/out_Shiftop/out_dest/out_illegal  registered head entry
//   perf_issued         accepted-entry count (optional)
//   perf_stall          in_valid && !in_ready cycle count (optional)
module shift_issue
  import shift_issue_pkg::*;
#(
  parameter int DATA_WIDTH = SHIFT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_rs_val,
  input  logic [DATA_WIDTH-1:0] in_rt_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A,
  output logic [4:0]            out_B,
  output logic [1:0]            out_Shiftop,
  output logic [4:0]            out_dest,
  output logic                  out_illegal,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
);

  buf_state_e            state_r;

  logic [DATA_WIDTH-1:0] dec_a_s;
  logic [4:0]            dec_b_s;
  logic [1:0]            dec_op_s;
  logic [4:0]            dec_dest_s;
  logic                  dec_ill_s;

  logic [DATA_WIDTH-1:0] slot0_a_r,    slot1_a_r;
  logic [4:0]            slot0_b_r,    slot1_b_r;
  logic [1:0]            slot0_op_r,   slot1_op_r;
  logic [4:0]            slot0_dest_r, slot1_dest_r;
  logic                  slot0_ill_r,  slot1_ill_r;

  logic                  in_ready_s;
  logic                  push_s;
  logic                  pop_s;

  shift_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .inst    (in_inst),
    .rs_val  (in_rs_val),
    .rt_val  (in_rt_val),
    .a       (dec_a_s),
    .b       (dec_b_s),
    .shiftop (dec_op_s),
    .dest    (dec_dest_s),
    .illegal (dec_ill_s)
  );

  // in_ready depends only on occupancy, never on out_ready
  assign in_ready_s = !rst && (state_r != ST_FULL);
  assign push_s     = in_valid && in_ready_s;
  assign pop_s      = (state_r != ST_EMPTY) && out_ready;

  assign in_ready    = in_ready_s;
  assign out_valid   = (state_r != ST_EMPTY);
  assign out_A       = slot0_a_r;
  assign out_B       = slot0_b_r;
  assign out_Shiftop = slot0_op_r;
  assign out_dest    = slot0_dest_r;
  assign out_illegal = slot0_ill_r;

  // Skid-buffer FSM and slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      slot0_a_r    <= '0;
      slot0_b_r    <= 5'd0;
      slot0_op_r   <= 2'b00;
      slot0_dest_r <= 5'd0;
      slot0_ill_r  <= 1'b0;
      slot1_a_r    <= '0;
      slot1_b_r    <= 5'd0;
      slot1_op_r   <= 2'b00;
      slot1_dest_r <= 5'd0;
      slot1_ill_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            slot0_a_r    <= dec_a_s;
            slot0_b_r    <= dec_b_s;
            slot0_op_r   <= dec_op_s;
            slot0_dest_r <= dec_dest_s;
            slot0_ill_r  <= dec_ill_s;
            state_r      <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({push_s, pop_s})
            2'b10: begin
              slot1_a_r    <= dec_a_s;
              slot1_b_r    <= dec_b_s;
              slot1_op_r   <= dec_op_s;
              slot1_dest_r <= dec_dest_s;
              slot1_ill_r  <= dec_ill_s;
              state_r      <= ST_FULL;
            end
            2'b01: begin
              state_r <= ST_EMPTY;
            end
            2'b11: begin
              // Head consumed this cycle; new entry takes its place
              slot0_a_r    <= dec_a_s;
              slot0_b_r    <= dec_b_s;
              slot0_op_r   <= dec_op_s;
              slot0_dest_r <= dec_dest_s;
              slot0_ill_r  <= dec_ill_s;
            end
            default: begin
              state_r <= ST_ONE;
            end
          endcase
        end
        ST_FULL: begin
          if (pop_s) begin
            slot0_a_r    <= slot1_a_r;
            slot0_b_r    <= slot1_b_r;
            slot0_op_r   <= slot1_op_r;
            slot0_dest_r <= slot1_dest_r;
            slot0_ill_r  <= slot1_ill_r;
            state_r      <= ST_ONE;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef SHIFT_ISSUE_PERF_EN
  logic [31:0] perf_issued_r;
  logic [31:0] perf_stall_r;

  // Issue and stall counters, wrapping naturally at 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      if (push_s) begin
        perf_issued_r <= perf_issued_r + 32'd1;
      end
      if (in_valid && !in_ready_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_r;
  assign perf_stall  = perf_stall_r;
`else
  assign perf_issued = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_shift_issue.sv
// tb_shift_issue
//   Directed self-checking bench for shift_issue.  Inputs change 1 time unit
//   after a rising edge; outputs are checked in that same quiet window.
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [4:0]  out_B;
  logic [1:0]  out_Shiftop;
  logic [4:0]  out_dest;
  logic        out_illegal;
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_A       (out_A),
    .out_B       (out_B),
    .out_Shiftop (out_Shiftop),
    .out_dest    (out_dest),
    .out_illegal (out_illegal),
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full head entry plus handshake flags
  task automatic check_head(input string tag, input logic v, input logic [31:0] a,
                            input logic [4:0] b, input logic [1:0] op,
                            input logic [4:0] d, input logic ill, input logic rdy);
    check({tag, ".valid"},   {31'd0, out_valid},   {31'd0, v});
    check({tag, ".A"},       out_A,                a);
    check({tag, ".B"},       {27'd0, out_B},       {27'd0, b});
    check({tag, ".Shiftop"}, {30'd0, out_Shiftop}, {30'd0, op});
    check({tag, ".dest"},    {27'd0, out_dest},    {27'd0, d});
    check({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    check({tag, ".in_ready"},{31'd0, in_ready},    {31'd0, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid  = v;
    in_inst   = inst;
    in_rs_val = rs;
    in_rt_val = rt;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    step();
    check_head("reset", 1'b0, 32'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    check("reset.perf_issued", perf_issued, 32'd0);
    check("reset.perf_stall",  perf_stall,  32'd0);
    rst = 1'b0;
    #1;
    check("release.in_ready", {31'd0, in_ready}, 32'd1);

    // sll rd=2, shamt=4
    out_ready = 1'b1;
    drive(1'b1, 32'h0009_1100, 32'h0000_001F, 32'h0000_00F0);
    step();
    check_head("sll", 1'b1, 32'h0000_00F0, 5'd4, 2'b00, 5'd2, 1'b0, 1'b1);

    // srav pushed while sll is popped (push+pop in ONE)
    drive(1'b1, 32'h00A6_3807, 32'h0000_0023, 32'h8000_0000);
    step();
    check_head("srav", 1'b1, 32'h8000_0000, 5'd3, 2'b11, 5'd7, 1'b0, 1'b1);

    // illegal funct, A passes through
    drive(1'b1, 32'h0000_0001, 32'h0000_0005, 32'h1234_5678);
    step();
    check_head("ill_funct", 1'b1, 32'h1234_5678, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);

    // illegal opcode with sll funct, dest still passed through
    drive(1'b1, 32'h2009_1100, 32'h0000_0000, 32'h0000_0042);
    step();
    check_head("ill_opcode", 1'b1, 32'h0000_0042, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1);

    // drain to EMPTY
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    check("drain.valid",    {31'd0, out_valid}, 32'd0);
    check("drain.in_ready", {31'd0, in_ready},  32'd1);

    // Backpressure: E1 srl rd=3 shamt=5, E2 srlv rd=4 rs=0x3F, E3 sllv rd=5 rs=0x41
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_1942, 32'h0000_0000, 32'hAAAA_0000);
    step();
    check_head("bp.e1", 1'b1, 32'hAAAA_0000, 5'd5, 2'b10, 5'd3, 1'b0, 1'b1);
    drive(1'b1, 32'h0000_2006, 32'h0000_003F, 32'h0000_0055);
    step();
    check_head("bp.full", 1'b1, 32'hAAAA_0000, 5'd5, 2'b10, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_2804, 32'h0000_0041, 32'h0000_0077);
    step();
    check_head("bp.stall", 1'b1, 32'hAAAA_0000, 5'd5, 2'b10, 5'd3, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    check_head("bp.e2", 1'b1, 32'h0000_0055, 5'd31, 2'b10, 5'd4, 1'b0, 1'b1);
    step();
    check_head("bp.e3", 1'b1, 32'h0000_0077, 5'd1, 2'b00, 5'd5, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    check("bp.empty", {31'd0, out_valid}, 32'd0);

`ifndef SHIFT_ISSUE_PERF_EN
    check("perf.tied_issued", perf_issued, 32'd0);
    check("perf.tied_stall",  perf_stall,  32'd0);
`endif

    // Reset while FULL, asserted mid-cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h0009_1100, 32'h0000_0000, 32'h0000_00F0);
    step();
    drive(1'b1, 32'h00A6_3807, 32'h0000_0023, 32'h8000_0000);
    step();
    check("midrst.full", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check_head("midrst", 1'b0, 32'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    check("midrst.perf_issued", perf_issued, 32'd0);
    check("midrst.perf_stall",  perf_stall,  32'd0);
    step();
    rst = 1'b0;
    #1;
    check("postrst.in_ready", {31'd0, in_ready},  32'd1);
    check("postrst.valid",    {31'd0, out_valid}, 32'd0);
    step();
    check("postrst.hold", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
